seq_div: RTL and testbench
==========================

# seq_div

Multi-cycle, parametrised restoring divider producing quotient and remainder for DATAWIDTH-bit operands under a start/done handshake. It is the sequential successor to the combinational DIV datapath component. It trades DATAWIDTH+1 cycles of latency for a single subtractor, and adds remainder, divide-by-zero detection and optional signed operation. It sits in the scheduled datapath wherever a DIV/MOD operation is bound to a multi-cycle functional unit.

## Interface
- DATAWIDTH, default 8: operand and result width in bits, minimum 2.
- Clk  in  1  rising-edge clock.
- Rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only while idle.
- a  in  DATAWIDTH  dividend; sampled with start.
- b  in  DATAWIDTH  divisor; sampled with start.
- sgn  in  1  signed-mode select; sampled with start. Present only with SEQ_DIV_SIGNED_EN.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; results valid.
- quot  out  DATAWIDTH  quotient; held until the next accepted start.
- rem  out  DATAWIDTH  remainder; held until the next accepted start.
- dbz  out  1  divide-by-zero flag for the current result; held with quot.

## Operation
- States:
  - IDLE: waits for start.
  - CALC: one restoring iteration per cycle, MSB first.
  - DONE: registers results and pulses done.
- Transitions:
  - IDLE + start with b≠0 → CALC. Operands are latched and the iteration counter is cleared.
  - IDLE + start with b=0 → DONE. CALC is skipped.
  - CALC when the counter reaches DATAWIDTH-1 → DONE.
  - DONE → IDLE, unconditionally.
- Datapath:
  - Partial remainder register is DATAWIDTH+1 bits wide.
  - Each step shifts in the next dividend bit and trial-subtracts the divisor.
  - A quotient bit of 1 keeps the difference; a quotient bit of 0 restores the previous value.
- Accepted start clears dbz.
- start while busy or in DONE is ignored, with no queuing. Operand changes during CALC have no effect.
- Divide by zero: quot = all ones, rem = a (as sampled), dbz = 1.
- Unsigned results satisfy a = quot·b + rem with rem < b.
- Rst in any state:
  - State returns to IDLE and any in-flight operation is discarded.
  - busy, done, dbz, quot and rem all go to 0.

## Timing
- Start accepted at edge k, b≠0:
  - busy = 1 after edges k … k+DATAWIDTH.
  - done = 1 for exactly one cycle after edge k+DATAWIDTH+1.
  - busy = 0 in that same cycle.
  - Latency is DATAWIDTH+1 cycles from accept to done.
- Divide by zero: done pulses after edge k+1, and busy stays 0.
- quot, rem and dbz update at the edge that raises done.
- A new start may be accepted in the cycle after done (back-to-back throughput: one result per DATAWIDTH+2 cycles).
- No combinational path from inputs to outputs.

## Configuration
- SEQ_DIV_SIGNED_EN defined:
  - The sgn port exists.
  - With sgn = 1, operands are two's complement. They are converted to magnitudes at accept and the unsigned core runs on the magnitudes.
  - Quotient is negated when the operand signs differ, so division truncates toward zero.
  - Remainder takes the sign of the dividend.
  - Most-negative ÷ −1 gives quot = most-negative (wrap) and rem = 0.
  - Signed divide by zero gives quot = all ones (−1) and rem = a.
  - Conversion and fix-up add no cycles.
- SEQ_DIV_SIGNED_EN undefined: no sgn port, unsigned only, and no sign logic is synthesised.

## Structure
- Package seq_div_pkg holds:
  - The state enum typedef (IDLE, CALC, DONE).
  - A function returning the counter width, $clog2(DATAWIDTH).
- Sub-module div_step: combinational single restoring step. It takes the partial remainder and divisor and returns the next partial remainder and the quotient bit. It is instantiated once.

## Test plan
All scenarios use DATAWIDTH = 8.
- a=20, b=15, start for one cycle → done 9 cycles after accept; quot=1, rem=5, dbz=0.
- Back-to-back 7/3 then 25/5, each start in the cycle after the previous done → quot=2, rem=1; then quot=5, rem=0.
- a=255, b=1 and a=3, b=200 → quot=255, rem=0; then quot=0, rem=3.
- a=42, b=0 → done 2 cycles after asserting start; quot=0xFF, rem=42, dbz=1, busy never high. A following 10/2 → dbz=0, quot=5.
- start re-pulsed with new operands mid-CALC, then Rst asserted mid-CALC on a later operation:
  - The re-pulse is ignored and the original result is delivered.
  - After Rst, all outputs read 0, no done pulse appears, and the next start works normally.
- With SEQ_DIV_SIGNED_EN and sgn=1:
  - −7 / 2 → quot=0xFD, rem=0xFF.
  - 7 / −2 → quot=0xFD, rem=0x01.
  - −128 / −1 → quot=0x80, rem=0.

Source files
------------

// File: rtl/seq_div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package seq_div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   // Iteration counter width for a given operand width.
   function automatic int unsigned cnt_width(input int unsigned dw);
      return $clog2(dw);
   endfunction

endpackage : seq_div_pkg

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract, restore on borrow.
module div_step #(
   parameter int unsigned DATAWIDTH = 8
) (
   input  logic [DATAWIDTH:0]   prem_i,
   input  logic                 bit_i,
   input  logic [DATAWIDTH-1:0] dvsr_i,
   output logic [DATAWIDTH:0]   prem_o,
   output logic                 qbit_o
);

   localparam int unsigned W = DATAWIDTH;

   logic [W+1:0] shifted;
   logic [W+1:0] diff;

   always_comb begin
      shifted = {prem_i, bit_i};
      diff    = shifted - {2'b00, dvsr_i};
      // No borrow out of the top bit means the divisor fit.
      qbit_o  = ~diff[W+1];
      prem_o  = qbit_o ? diff[W:0] : shifted[W:0];
   end

endmodule : div_step

// File: rtl/seq_div.sv
// Multi-cycle restoring divider (quotient, remainder, divide-by-zero) with start/done handshake.
// Define SEQ_DIV_SIGNED_EN to add the sgn port and two's-complement operation.
module seq_div
   import seq_div_pkg::*;
#(
   parameter int unsigned DATAWIDTH = 8
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 start,
   input  logic [DATAWIDTH-1:0] a,
   input  logic [DATAWIDTH-1:0] b,
`ifdef SEQ_DIV_SIGNED_EN
   input  logic                 sgn,
`endif
   output logic                 busy,
   output logic                 done,
   output logic [DATAWIDTH-1:0] quot,
   output logic [DATAWIDTH-1:0] rem,
   output logic                 dbz
);

   localparam int unsigned W  = DATAWIDTH;
   localparam int unsigned CW = cnt_width(DATAWIDTH);

   state_e         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [W:0]     prem_q, prem_d;
   logic [W-1:0]   divd_q, divd_d;
   logic [W-1:0]   dvsr_q, dvsr_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic [W-1:0]   quot_q, quot_d;
   logic [W-1:0]   rem_q, rem_d;
   logic           dbz_q, dbz_d;

   logic [W:0]     step_prem;
   logic           step_qbit;
   logic [W-1:0]   mag_a, mag_b;
   logic [W-1:0]   q_fix, r_fix;

`ifdef SEQ_DIV_SIGNED_EN
   logic           negq_q, negq_d;
   logic           negr_q, negr_d;
   logic           a_neg, b_neg;

   // Magnitudes at accept; the core only ever sees unsigned operands.
   always_comb begin
      a_neg = sgn & a[W-1];
      b_neg = sgn & b[W-1];
      mag_a = a_neg ? W'(-a) : a;
      mag_b = b_neg ? W'(-b) : b;
      q_fix = negq_q ? W'(-divd_q) : divd_q;
      r_fix = negr_q ? W'(-prem_q[W-1:0]) : prem_q[W-1:0];
   end
`else
   always_comb begin
      mag_a = a;
      mag_b = b;
      q_fix = divd_q;
      r_fix = prem_q[W-1:0];
   end
`endif

   div_step #(.DATAWIDTH(W)) u_step (
      .prem_i (prem_q),
      .bit_i  (divd_q[W-1]),
      .dvsr_i (dvsr_q),
      .prem_o (step_prem),
      .qbit_o (step_qbit)
   );

   // Next-state and datapath update; divd_q shifts dividend bits out and quotient bits in.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      prem_d  = prem_q;
      divd_d  = divd_q;
      dvsr_d  = dvsr_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
`ifdef SEQ_DIV_SIGNED_EN
      negq_d  = negq_q;
      negr_d  = negr_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               dbz_d  = 1'b0;
               cnt_d  = '0;
               prem_d = '0;
               dvsr_d = mag_b;
`ifdef SEQ_DIV_SIGNED_EN
               negq_d = a_neg ^ b_neg;
               negr_d = a_neg;
`endif
               if (b == '0) begin
                  state_d = DONE;
                  divd_d  = a;
               end else begin
                  state_d = CALC;
                  busy_d  = 1'b1;
                  divd_d  = mag_a;
               end
            end
         end
         CALC: begin
            prem_d = step_prem;
            divd_d = {divd_q[W-2:0], step_qbit};
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(W - 1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            if (dvsr_q == '0) begin
               quot_d = '1;
               rem_d  = divd_q;
               dbz_d  = 1'b1;
            end else begin
               quot_d = q_fix;
               rem_d  = r_fix;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         prem_q  <= '0;
         divd_q  <= '0;
         dvsr_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         quot_q  <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         prem_q  <= prem_d;
         divd_q  <= divd_d;
         dvsr_q  <= dvsr_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
`ifdef SEQ_DIV_SIGNED_EN
         negq_q  <= negq_d;
         negr_q  <= negr_d;
`endif
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign quot = quot_q;
   assign rem  = rem_q;
   assign dbz  = dbz_q;

endmodule : seq_div

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div (DATAWIDTH=8); signed cases run when SEQ_DIV_SIGNED_EN is defined.
module tb_seq_div;

   localparam int unsigned W = 8;

   logic         Clk;
   logic         Rst;
   logic         start;
   logic         sgn;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] quot;
   logic [W-1:0] rem;
   logic         dbz;

   typedef struct packed {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         z;
   } res_t;

   res_t sb[$];
   int   checks;
   int   failures;

   seq_div #(.DATAWIDTH(W)) dut (
      .Clk   (Clk),
      .Rst   (Rst),
      .start (start),
      .a     (a),
      .b     (b),
`ifdef SEQ_DIV_SIGNED_EN
      .sgn   (sgn),
`endif
      .busy  (busy),
      .done  (done),
      .quot  (quot),
      .rem   (rem),
      .dbz   (dbz)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Reference: integer division truncating toward zero, remainder follows the dividend.
   function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      res_t m;
      int   ix;
      int   iy;
      if (y == '0) begin
         m.q = '1;
         m.r = x;
         m.z = 1'b1;
         return m;
      end
      m.z = 1'b0;
      if (s) begin
         ix  = int'($signed(x));
         iy  = int'($signed(y));
         m.q = W'(ix / iy);
         m.r = W'(ix % iy);
      end else begin
         m.q = x / y;
         m.r = x % y;
      end
      return m;
   endfunction

   // Present one request for a single edge, then scramble operands to show they are latched.
   task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      a     = x;
      b     = y;
      sgn   = s;
      start = 1'b1;
      sb.push_back(model(x, y, s));
      @(posedge Clk);
      #1;
      start = 1'b0;
      a     = W'($urandom);
      b     = W'($urandom);
   endtask

   task automatic wait_done(input int budget, output int n, output bit busy_all, output bit busy_any);
      n        = 0;
      busy_all = 1'b1;
      busy_any = 1'b0;
      while (done !== 1'b1 && n < budget) begin
         busy_all = busy_all & (busy === 1'b1);
         busy_any = busy_any | (busy === 1'b1);
         @(posedge Clk);
         #1;
         n++;
      end
   endtask

   task automatic test_reset();
      Rst   = 1'b1;
      start = 1'b0;
      sgn   = 1'b0;
      a     = '0;
      b     = '0;
      repeat (3) @(posedge Clk);
      #1;
      checks++;
      if ({busy, done, dbz, quot, rem} !== '0) begin
         failures++;
         $display("FAIL reset: busy=%b done=%b dbz=%b quot=%0d rem=%0d, want all 0", busy, done, dbz, quot, rem);
      end
      Rst = 1'b0;
      @(posedge Clk);
      #1;
   endtask

   task automatic test_basic();
      int   n;
      bit   ba;
      bit   bany;
      res_t e;
      start_op(8'd20, 8'd15, 1'b0);
      wait_done(20, n, ba, bany);
      checks++;
      if (done !== 1'b1 || n != 9) begin
         failures++;
         $display("FAIL basic_latency: done=%b after %0d edges, want done=1 after 9", done, n);
      end
      checks++;
      if (!ba || busy !== 1'b0) begin
         failures++;
         $display("FAIL basic_busy: busy_all=%0d busy_at_done=%b, want 1 and 0", ba, busy);
      end
      e = sb.pop_front();
      checks++;
      if ({quot, rem, dbz} !== e) begin
         failures++;
         $display("FAIL basic_result: quot=%0d rem=%0d dbz=%b, want %0d %0d %b", quot, rem, dbz, e.q, e.r, e.z);
      end
      @(posedge Clk);
      #1;
      checks++;
      if (done !== 1'b0) begin
         failures++;
         $display("FAIL basic_pulse: done=%b one cycle later, want 0", done);
      end
   endtask

   task automatic test_back_to_back();
      int   n;
      bit   ba;
      bit   bany;
      res_t e;
      logic [W-1:0] xs [4] = '{8'd7, 8'd25, 8'd255, 8'd3};
      logic [W-1:0] ys [4] = '{8'd3, 8'd5, 8'd1, 8'd200};
      for (int i = 0; i < 4; i++) begin
         start_op(xs[i], ys[i], 1'b0);
         wait_done(20, n, ba, bany);
         checks++;
         if (done !== 1'b1 || n != 9) begin
            failures++;
            $display("FAIL b2b_latency[%0d]: done=%b after %0d edges, want 1 after 9", i, done, n);
         end
         e = sb.pop_front();
         checks++;
         if ({quot, rem, dbz} !== e) begin
            failures++;
            $display("FAIL b2b_result[%0d]: quot=%0d rem=%0d dbz=%b, want %0d %0d %b", i, quot, rem, dbz, e.q, e.r, e.z);
         end
      end
   endtask

   task automatic test_dbz();
      int   n;
      bit   ba;
      bit   bany;
      res_t e;
      start_op(8'd42, 8'd0, 1'b0);
      wait_done(10, n, ba, bany);
      checks++;
      if (done !== 1'b1 || n != 1 || bany || busy !== 1'b0) begin
         failures++;
         $display("FAIL dbz_timing: done=%b n=%0d busy_seen=%0d, want done=1 n=1 busy never", done, n, bany);
      end
      e = sb.pop_front();
      checks++;
      if ({quot, rem, dbz} !== e) begin
         failures++;
         $display("FAIL dbz_result: quot=%0d rem=%0d dbz=%b, want %0d %0d %b", quot, rem, dbz, e.q, e.r, e.z);
      end
      start_op(8'd10, 8'd2, 1'b0);
      checks++;
      if (dbz !== 1'b0) begin
         failures++;
         $display("FAIL dbz_clear: dbz=%b after accept, want 0", dbz);
      end
      wait_done(20, n, ba, bany);
      e = sb.pop_front();
      checks++;
      if (done !== 1'b1 || {quot, rem, dbz} !== e) begin
         failures++;
         $display("FAIL dbz_next: done=%b quot=%0d rem=%0d dbz=%b, want 1 %0d %0d %b", done, quot, rem, dbz, e.q, e.r, e.z);
      end
   endtask

   task automatic test_ignore_and_reset();
      int   n;
      bit   ba;
      bit   bany;
      bit   extra;
      res_t e;
      start_op(8'd100, 8'd7, 1'b0);
      repeat (3) @(posedge Clk);
      #1;
      a     = 8'd9;
      b     = 8'd3;
      start = 1'b1;
      @(posedge Clk);
      #1;
      start = 1'b0;
      wait_done(20, n, ba, bany);
      e = sb.pop_front();
      checks++;
      if (done !== 1'b1 || {quot, rem, dbz} !== e) begin
         failures++;
         $display("FAIL ignore_result: done=%b quot=%0d rem=%0d dbz=%b, want 1 %0d %0d %b", done, quot, rem, dbz, e.q, e.r, e.z);
      end
      extra = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge Clk);
         #1;
         extra = extra | (done === 1'b1) | (busy === 1'b1);
      end
      checks++;
      if (extra) begin
         failures++;
         $display("FAIL ignore_queued: extra activity=%0d after ignored start, want 0", extra);
      end
      start_op(8'd200, 8'd9, 1'b0);
      repeat (4) @(posedge Clk);
      #1;
      Rst = 1'b1;
      @(posedge Clk);
      #1;
      Rst = 1'b0;
      sb.delete();
      checks++;
      if ({busy, done, dbz, quot, rem} !== '0) begin
         failures++;
         $display("FAIL midcalc_reset: busy=%b done=%b dbz=%b quot=%0d rem=%0d, want all 0", busy, done, dbz, quot, rem);
      end
      extra = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge Clk);
         #1;
         extra = extra | (done === 1'b1) | (busy === 1'b1);
      end
      checks++;
      if (extra) begin
         failures++;
         $display("FAIL reset_discard: activity=%0d after reset, want 0", extra);
      end
      start_op(8'd10, 8'd2, 1'b0);
      wait_done(20, n, ba, bany);
      e = sb.pop_front();
      checks++;
      if (done !== 1'b1 || n != 9 || {quot, rem, dbz} !== e) begin
         failures++;
         $display("FAIL post_reset: done=%b n=%0d quot=%0d rem=%0d dbz=%b, want 1 9 %0d %0d %b", done, n, quot, rem, dbz, e.q, e.r, e.z);
      end
   endtask

   task automatic test_random();
      int   n;
      bit   ba;
      bit   bany;
      res_t e;
      logic [W-1:0] x;
      logic [W-1:0] y;
      for (int i = 0; i < 16; i++) begin
         x = W'($urandom_range(0, 255));
         y = (i % 5 == 0) ? '0 : W'($urandom_range(1, 255));
         start_op(x, y, 1'b0);
         wait_done(20, n, ba, bany);
         e = sb.pop_front();
         checks++;
         if (done !== 1'b1 || {quot, rem, dbz} !== e) begin
            failures++;
            $display("FAIL random[%0d] %0d/%0d: done=%b quot=%0d rem=%0d dbz=%b, want 1 %0d %0d %b", i, x, y, done, quot, rem, dbz, e.q, e.r, e.z);
         end
      end
   endtask

`ifdef SEQ_DIV_SIGNED_EN
   task automatic test_signed();
      int   n;
      bit   ba;
      bit   bany;
      res_t e;
      logic [W-1:0] xs [6] = '{8'hF9, 8'h07, 8'h80, 8'hF9, 8'h85, 8'h80};
      logic [W-1:0] ys [6] = '{8'h02, 8'hFE, 8'hFF, 8'h02, 8'h00, 8'h07};
      logic         ss [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 6; i++) begin
         start_op(xs[i], ys[i], ss[i]);
         wait_done(20, n, ba, bany);
         e = sb.pop_front();
         checks++;
         if (done !== 1'b1 || {quot, rem, dbz} !== e) begin
            failures++;
            $display("FAIL signed[%0d]: done=%b quot=%h rem=%h dbz=%b, want 1 %h %h %b", i, done, quot, rem, dbz, e.q, e.r, e.z);
         end
      end
   endtask
`endif

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_dbz();
      test_ignore_and_reset();
      test_random();
`ifdef SEQ_DIV_SIGNED_EN
      test_signed();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_seq_div
